sync_mod_counter: RTL and testbench

//  Fully synchronous, parametrised modulo-N up/down counter; successor to the 3-bit ripple JK counter.
//  All state changes on the single clock edge: no derived clocks, no ripple delay.

---
 rtl/sync_mod_counter.sv | 98 +++++++++
 tb/tb_sync_mod_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sync_mod_counter.sv
// Fully synchronous modulo-N up/down counter with load, enable, direction,
// wrap / saturate / one-shot modes, terminal count and cascade carry.
// Chain stages by feeding carry_out of one stage into en of the next.
module sync_mod_counter #(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry_out,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
  localparam logic [1:0]       M_SAT     = 2'b01;
  localparam logic [1:0]       M_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             oneshot_mode;
  logic             sat_mode;
  logic             active;
  logic [WIDTH-1:0] load_clamped;

  assign oneshot_mode = (mode == M_ONESHOT);
  assign sat_mode     = (mode == M_SAT);
  // Wrap, reserved and saturate modes always count; one-shot only while running.
  assign active       = oneshot_mode ? (state_q == S_RUN) : 1'b1;
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  assign tc        = (count_q == (up ? MAX_VAL : '0));
  assign carry_out = en & tc & active & ~sat_mode;
  assign count     = count_q;
  assign wrap      = wrap_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

  // Next-state logic: load > start > count; FSM falls back to IDLE outside one-shot.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    if (!oneshot_mode) begin
      state_d = S_IDLE;
    end
    if (load) begin
      count_d = load_clamped;
      if (oneshot_mode) begin
        state_d = S_IDLE;
      end
    end else if (oneshot_mode && start && (state_q != S_RUN)) begin
      count_d = up ? '0 : MAX_VAL;
      state_d = S_RUN;
    end else if (en && active) begin
      if (!tc) begin
        count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end else if (oneshot_mode) begin
        state_d = S_DONE;
      end else if (!sat_mode) begin
        count_d = up ? '0 : MAX_VAL;
        wrap_d  = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= RST_COUNT;
      state_q <= S_IDLE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_sync_mod_counter.sv
// Directed table-driven bench for sync_mod_counter: an 8-count instance,
// a 10-count instance and a two-stage cascade of 4-count instances.
module tb_sync_mod_counter;

  typedef struct {
    bit       sel;   // 0: modulo-8 instance, 1: modulo-10 instance
    bit       rst_n;
    bit       en;
    bit       up;
    bit [1:0] mode;
    bit       load;
    bit [3:0] lv;
    bit       start;
    bit [3:0] cnt;
    bit       tc;
    bit       co;
    bit       wr;
    bit       busy;
    bit       done;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Modulo-8 instance
  logic       a_rst = 1'b0, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0, a_start = 1'b0;
  logic [1:0] a_mode = 2'b00;
  logic [2:0] a_lv = '0, a_count;
  logic       a_tc, a_co, a_wr, a_busy, a_done;

  // Modulo-10 instance, reset value 2
  logic       b_rst = 1'b0, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0, b_start = 1'b0;
  logic [1:0] b_mode = 2'b00;
  logic [3:0] b_lv = '0, b_count;
  logic       b_tc, b_co, b_wr, b_busy, b_done;

  // Cascade of two modulo-4 stages
  logic       c_rst = 1'b0, c_en = 1'b0;
  logic [1:0] c0_count, c1_count;
  logic       c0_tc, c0_co, c0_wr, c0_busy, c0_done;
  logic       c1_tc, c1_co, c1_wr, c1_busy, c1_done;

  sync_mod_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset(a_rst), .en(a_en), .up(a_up), .mode(a_mode), .load(a_load),
    .load_val(a_lv), .start(a_start), .count(a_count), .tc(a_tc), .carry_out(a_co),
    .wrap(a_wr), .busy(a_busy), .done(a_done));

  sync_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(2)) dut_b (
    .clk(clk), .reset(b_rst), .en(b_en), .up(b_up), .mode(b_mode), .load(b_load),
    .load_val(b_lv), .start(b_start), .count(b_count), .tc(b_tc), .carry_out(b_co),
    .wrap(b_wr), .busy(b_busy), .done(b_done));

  sync_mod_counter #(.WIDTH(2), .MODULUS(4), .RESET_VAL(0)) dut_c0 (
    .clk(clk), .reset(c_rst), .en(c_en), .up(1'b1), .mode(2'b00), .load(1'b0),
    .load_val(2'b00), .start(1'b0), .count(c0_count), .tc(c0_tc), .carry_out(c0_co),
    .wrap(c0_wr), .busy(c0_busy), .done(c0_done));

  sync_mod_counter #(.WIDTH(2), .MODULUS(4), .RESET_VAL(0)) dut_c1 (
    .clk(clk), .reset(c_rst), .en(c0_co), .up(1'b1), .mode(2'b00), .load(1'b0),
    .load_val(2'b00), .start(1'b0), .count(c1_count), .tc(c1_tc), .carry_out(c1_co),
    .wrap(c1_wr), .busy(c1_busy), .done(c1_done));

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(bit sel, bit rst_n, bit en, bit up, bit [1:0] mode, bit load,
                              bit [3:0] lv, bit start, bit [3:0] cnt, bit tc, bit co,
                              bit wr, bit busy, bit done);
    vec_t v;
    v.sel = sel; v.rst_n = rst_n; v.en = en; v.up = up; v.mode = mode; v.load = load;
    v.lv = lv; v.start = start; v.cnt = cnt; v.tc = tc; v.co = co; v.wr = wr;
    v.busy = busy; v.done = done;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [8:0] act, exp;
    logic [3:0] cexp;

    // ---- modulo-8: wrap up 0..7,0,1 ----
    add(0, 0,0,1,2'd0,0,4'd0,0, 4'd0,0,0,0,0,0);
    for (int k = 1; k <= 7; k++) add(0, 1,1,1,2'd0,0,4'd0,0, 4'(k), k==7, k==7, 0,0,0);
    add(0, 1,1,1,2'd0,0,4'd0,0, 4'd0,0,0,1,0,0);
    add(0, 1,1,1,2'd0,0,4'd0,0, 4'd1,0,0,0,0,0);
    // ---- saturate up to 7, hold, then down ----
    for (int k = 2; k <= 7; k++) add(0, 1,1,1,2'd1,0,4'd0,0, 4'(k), k==7, 0, 0,0,0);
    add(0, 1,1,1,2'd1,0,4'd0,0, 4'd7,1,0,0,0,0);
    add(0, 1,1,0,2'd1,0,4'd0,0, 4'd6,0,0,0,0,0);
    add(0, 1,1,0,2'd1,0,4'd0,0, 4'd5,0,0,0,0,0);
    // ---- one-shot run 0..7, done, hold, restart ----
    add(0, 1,1,1,2'd2,0,4'd0,1, 4'd0,0,0,0,1,0);
    for (int k = 1; k <= 7; k++) add(0, 1,1,1,2'd2,0,4'd0,0, 4'(k), k==7, k==7, 0,1,0);
    add(0, 1,1,1,2'd2,0,4'd0,0, 4'd7,1,0,0,0,1);
    add(0, 1,1,1,2'd2,0,4'd0,0, 4'd7,1,0,0,0,1);
    add(0, 1,1,1,2'd2,0,4'd0,1, 4'd0,0,0,0,1,0);
    // ---- reset mid one-shot with en/load/start high ----
    for (int k = 1; k <= 4; k++) add(0, 1,1,1,2'd2,0,4'd0,0, 4'(k),0,0,0,1,0);
    add(0, 0,1,1,2'd2,1,4'd5,1, 4'd0,0,0,0,0,0);
    // ---- load beats enable, then en=0 holds ----
    add(0, 1,1,1,2'd0,1,4'd5,0, 4'd5,0,0,0,0,0);
    for (int k = 0; k < 3; k++) add(0, 1,0,1,2'd0,0,4'd0,0, 4'd5,0,0,0,0,0);
    // ---- down wrap 1,0,7,6 ----
    add(0, 1,1,0,2'd0,1,4'd1,0, 4'd1,0,0,0,0,0);
    add(0, 1,1,0,2'd0,0,4'd0,0, 4'd0,1,1,0,0,0);
    add(0, 1,1,0,2'd0,0,4'd0,0, 4'd7,0,0,1,0,0);
    add(0, 1,1,0,2'd0,0,4'd0,0, 4'd6,0,0,0,0,0);
    // ---- mode change drops FSM, load in one-shot drops FSM ----
    add(0, 1,0,1,2'd2,0,4'd0,1, 4'd0,0,0,0,1,0);
    add(0, 1,0,1,2'd0,0,4'd0,0, 4'd0,0,0,0,0,0);
    add(0, 1,0,1,2'd2,0,4'd0,1, 4'd0,0,0,0,1,0);
    add(0, 1,1,1,2'd2,1,4'd6,0, 4'd6,0,0,0,0,0);
    add(0, 1,1,1,2'd2,0,4'd0,0, 4'd6,0,0,0,0,0);
    // ---- reserved mode behaves as wrap; start ignored outside one-shot ----
    add(0, 1,1,1,2'd3,0,4'd0,0, 4'd7,1,1,0,0,0);
    add(0, 1,1,1,2'd3,0,4'd0,0, 4'd0,0,0,1,0,0);
    add(0, 1,0,1,2'd0,0,4'd0,1, 4'd0,0,0,0,0,0);
    // ---- modulo-10: reset value, down wrap, clamp, up wrap, saturate ----
    add(1, 0,0,1,2'd0,0,4'd0,0, 4'd2,0,0,0,0,0);
    add(1, 1,0,0,2'd0,1,4'd3,0, 4'd3,0,0,0,0,0);
    add(1, 1,1,0,2'd0,0,4'd0,0, 4'd2,0,0,0,0,0);
    add(1, 1,1,0,2'd0,0,4'd0,0, 4'd1,0,0,0,0,0);
    add(1, 1,1,0,2'd0,0,4'd0,0, 4'd0,1,1,0,0,0);
    add(1, 1,1,0,2'd0,0,4'd0,0, 4'd9,0,0,1,0,0);
    add(1, 1,1,0,2'd0,0,4'd0,0, 4'd8,0,0,0,0,0);
    add(1, 1,0,0,2'd0,1,4'd12,0, 4'd9,0,0,0,0,0);
    add(1, 1,1,1,2'd0,0,4'd0,0, 4'd0,0,0,1,0,0);
    add(1, 1,1,1,2'd0,0,4'd0,0, 4'd1,0,0,0,0,0);
    add(1, 1,1,1,2'd1,1,4'd8,0, 4'd8,0,0,0,0,0);
    add(1, 1,1,1,2'd1,0,4'd0,0, 4'd9,1,0,0,0,0);
    add(1, 1,1,1,2'd1,0,4'd0,0, 4'd9,1,0,0,0,0);
    add(1, 0,1,1,2'd1,1,4'd4,0, 4'd2,0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (!tbl[i].sel) begin
        a_rst = tbl[i].rst_n; a_en = tbl[i].en; a_up = tbl[i].up; a_mode = tbl[i].mode;
        a_load = tbl[i].load; a_lv = tbl[i].lv[2:0]; a_start = tbl[i].start;
      end else begin
        b_rst = tbl[i].rst_n; b_en = tbl[i].en; b_up = tbl[i].up; b_mode = tbl[i].mode;
        b_load = tbl[i].load; b_lv = tbl[i].lv; b_start = tbl[i].start;
      end
      @(posedge clk);
      #1;
      if (!tbl[i].sel) act = {1'b0, a_count, a_tc, a_co, a_wr, a_busy, a_done};
      else             act = {b_count, b_tc, b_co, b_wr, b_busy, b_done};
      exp = {tbl[i].cnt, tbl[i].tc, tbl[i].co, tbl[i].wr, tbl[i].busy, tbl[i].done};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL vec%0d dut%0d {count,tc,carry,wrap,busy,done}: got %0d,%b required %0d,%b",
                 i, tbl[i].sel, act[8:5], act[4:0], exp[8:5], exp[4:0]);
      end else begin
        $display("vec%0d dut%0d count=%0d flags=%b ok", i, tbl[i].sel, act[8:5], act[4:0]);
      end
    end

    // ---- cascade: 4-bit sequence 0..15 then back to 0 ----
    n_cmp++;
    if ({c1_count, c0_count} !== 4'd0) begin
      n_bad++;
      $display("FAIL cascade_reset: got %0d required 0", {c1_count, c0_count});
    end
    c_rst = 1'b1;
    c_en  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      cexp = 4'(i);
      n_cmp++;
      if ({c1_count, c0_count} !== cexp) begin
        n_bad++;
        $display("FAIL cascade step%0d: got %0d required %0d", i, {c1_count, c0_count}, cexp);
      end else begin
        $display("cascade step%0d count=%0d ok", i, {c1_count, c0_count});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
